// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Hits answer in one cycle; misses refill a full line over a req/ack port.
module icache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_flag,
  input  logic [31:0] addr,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - 2 - OW - IW;

  typedef enum logic [1:0] {
    IDLE,
    HIT,
    REFILL,
    RESP
  } state_t;

  state_t state;

  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic [OW-1:0] cnt;
  logic          flush_pend;

  logic [TW-1:0] a_tag;
  logic [IW-1:0] a_idx;
  logic [OW-1:0] a_off;
  logic          hit;
  logic          last;
  logic          unused;

  assign a_off  = addr[2 +: OW];
  assign a_idx  = addr[2+OW +: IW];
  assign a_tag  = addr[2+OW+IW +: TW];
  assign unused = ^addr[1:0];

  // a flush on the accept edge forces a miss
  assign hit  = valid_q[a_idx] && (tag_q[a_idx] == a_tag) && !flush;
  assign last = (cnt == OW'(LINE_WORDS-1));

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_q[{req_idx, cnt}] <= mem_rdata;
      if (last)
        tag_q[req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      read_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      req_tag    <= '0;
      req_idx    <= '0;
      req_off    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush)
            valid_q <= '0;
          if (read_flag) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            req_off <= a_off;
            if (hit) begin
              state     <= HIT;
              done      <= 1'b1;
              read_data <= data_q[{a_idx, a_off}];
            end else begin
              state    <= REFILL;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              cnt      <= '0;
              mem_addr <= {a_tag, a_idx, {OW{1'b0}}, 2'b00};
            end
          end
        end
        HIT: begin
          if (flush)
            valid_q <= '0;
          state <= IDLE;
        end
        REFILL: begin
          if (flush)
            flush_pend <= 1'b1;
          if (mem_ack) begin
            cnt      <= cnt + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (last) begin
              valid_q[req_idx] <= 1'b1;
              mem_req          <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              state            <= RESP;
              // earlier beats are already in the array
              read_data <= (req_off == cnt) ? mem_rdata
                         : data_q[{req_idx, req_off}];
            end
          end
        end
        RESP: begin
          if (flush || flush_pend)
            valid_q <= '0;
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
